frame_capture: RTL and testbench
================================

FRAME_CAPTURE -- requirements
Module: frame_capture

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, meaning pixels per line.
REQ-002 The block SHALL have parameter V_ACTIVE, default 480, meaning lines per frame.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: PCLK input 1, camera pixel clock, sole clock; RESET_N input 1, async active-low reset.
REQ-004 The block SHALL have the following remaining ports:
- VSYNC input 1: camera vertical sync, high = vertical blanking.
- HREF input 1: camera line-valid, high = active bytes.
- DATA_IN input 8: camera byte bus, sampled on PCLK rising edge.
- CAPTURE_EN input 1: arm capture.
- CONTINUOUS input 1: 1 = capture every frame, 0 = single frame.
- PIX_READY input 1: downstream can accept a pixel this cycle.
- PIX_DATA output 16: RGB565 pixel.
- PIX_VALID output 1: PIX_DATA qualified.
- PIX_X output 10: column of current pixel.
- PIX_Y output 9: row of current pixel.
- FRAME_START output 1: one-cycle pulse at frame start.
- FRAME_DONE output 1: one-cycle pulse at frame end.
- LINE_ERR output 1: sticky bad-line-length flag.
- OVERFLOW output 1: sticky dropped-pixel flag.
- FRAME_CNT output 8: completed-frame counter.

Function
REQ-005 The block SHALL register VSYNC and HREF once and detect edges by comparing the current input with its registered copy.
REQ-006 The FSM SHALL have states IDLE, WAIT_VS and ACTIVE.
- IDLE -> WAIT_VS when CAPTURE_EN=1.
- WAIT_VS -> ACTIVE on a VSYNC falling edge; FRAME_START pulses that cycle, and row, column and sticky flags clear.
- ACTIVE -> on a VSYNC rising edge, FRAME_DONE pulses and FRAME_CNT increments (8-bit wrap, 255 -> 0). The next state is WAIT_VS if CAPTURE_EN=1 and CONTINUOUS=1, otherwise IDLE.
REQ-007 Deasserting CAPTURE_EN in WAIT_VS SHALL return the FSM to IDLE; deasserting it in ACTIVE SHALL take effect only at frame end.
REQ-008 In ACTIVE with HREF=1, a byte-phase bit SHALL toggle every PCLK; phase 0 captures DATA_IN into PIX_DATA[15:8], phase 1 into PIX_DATA[7:0]. The phase bit SHALL clear whenever HREF=0.
REQ-009 PIX_VALID SHALL assert for exactly one cycle, the cycle after the phase-1 byte, and only if PIX_X < H_ACTIVE and PIX_Y < V_ACTIVE. Pixels beyond those limits SHALL be suppressed, not wrapped.
REQ-010 PIX_X SHALL start at 0 per line and increment after each valid pixel.
REQ-011 On an HREF falling edge in ACTIVE:
- PIX_X resets to 0.
- PIX_Y increments, saturating at V_ACTIVE.
- LINE_ERR sets if the pixel count differs from H_ACTIVE or a half pixel (odd byte count) is pending.
REQ-012 A VSYNC rising edge while HREF=1 SHALL close the line as in REQ-011, set LINE_ERR, and still produce FRAME_DONE.
REQ-013 If PIX_VALID=1 and PIX_READY=0, the pixel SHALL be dropped (no stall, no buffering) and OVERFLOW SHALL set.
REQ-014 LINE_ERR and OVERFLOW SHALL hold until the next FRAME_START or reset.
REQ-015 HREF and DATA_IN SHALL be ignored outside ACTIVE.
REQ-016 Total capture latency SHALL be 1 PCLK from the second byte to PIX_VALID.

Reset
REQ-017 Asserting RESET_N=0 SHALL asynchronously force:
- state IDLE;
- PIX_DATA=0, PIX_VALID=0, PIX_X=0, PIX_Y=0;
- FRAME_START=0, FRAME_DONE=0;
- LINE_ERR=0, OVERFLOW=0, FRAME_CNT=0;
- phase bit=0, edge registers=0.
REQ-018 Reset mid-frame SHALL discard the frame; after release the block SHALL wait for CAPTURE_EN and then a fresh VSYNC falling edge.
REQ-019 Reset release SHALL be synchronous to PCLK.

Structure
REQ-020 Shared package camera_pkg SHALL hold:
- the FSM state typedef;
- the RGB565 pixel typedef;
- default H_ACTIVE/V_ACTIVE constants;
- coordinate widths.
REQ-021 VSYNC/HREF edge detection SHALL be a sub-module sig_edge (registered input plus rise/fall pulses), instantiated twice.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Arm, then a 4x2 frame (H_ACTIVE=4, V_ACTIVE=2) with bytes 0x12,0x34,... -> 8 PIX_VALID pulses; first PIX_DATA=0x1234 at X=0,Y=0; FRAME_DONE once; FRAME_CNT=1; no flags.
- Line of 3 pixels with H_ACTIVE=4 -> LINE_ERR=1 after HREF fall; cleared at next FRAME_START.
- Odd byte count (7 bytes) on a line -> 3 pixels output, LINE_ERR=1.
- PIX_READY=0 during the 2nd pixel -> that pixel is not re-presented, OVERFLOW=1, remaining pixels continue.
- CONTINUOUS=0, three camera frames -> exactly one FRAME_START/FRAME_DONE pair, then IDLE.
- RESET_N pulsed low mid-line -> all outputs 0 immediately; no pixels until the next VSYNC falling edge after re-arm.
- FRAME_CNT preloaded by running 256 frames -> wraps to 0.

Source files
------------

// File: rtl/camera_pkg.sv
// Shared types and constants for the camera capture path: FSM states, the
// RGB565 pixel layout, default frame geometry and coordinate widths.
package camera_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int X_W          = 10;
    localparam int Y_W          = 9;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_ACTIVE  = 2'd2
    } cap_state_t;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    function automatic logic [Y_W-1:0] sat_inc_y(input logic [Y_W-1:0] v,
                                                 input logic [Y_W-1:0] lim);
        logic [Y_W-1:0] res;
        if (v >= lim) begin
            res = v;
        end else begin
            res = v + Y_W'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/sig_edge.sv
// Registers a single-bit input once and reports rising/falling edges by
// comparing the live input against its registered copy.
module sig_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic d_r;

    // Previous-cycle copy of the input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_r <= 1'b0;
        end else begin
            d_r <= d;
        end
    end

    assign rise = d & ~d_r;
    assign fall = ~d & d_r;

endmodule

// File: rtl/frame_capture.sv
// Captures camera byte pairs into RGB565 pixels with coordinates, frame
// framing pulses, sticky error flags and a completed-frame counter.
module frame_capture
    import camera_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic             PCLK,
    input  logic             RESET_N,
    input  logic             VSYNC,
    input  logic             HREF,
    input  logic [7:0]       DATA_IN,
    input  logic             CAPTURE_EN,
    input  logic             CONTINUOUS,
    input  logic             PIX_READY,
    output logic [15:0]      PIX_DATA,
    output logic             PIX_VALID,
    output logic [X_W-1:0]   PIX_X,
    output logic [Y_W-1:0]   PIX_Y,
    output logic             FRAME_START,
    output logic             FRAME_DONE,
    output logic             LINE_ERR,
    output logic             OVERFLOW,
    output logic [7:0]       FRAME_CNT
);

    localparam logic [X_W-1:0] H_X = X_W'(H_ACTIVE);
    localparam logic [X_W:0]   H_C = (X_W + 1)'(H_ACTIVE);
    localparam logic [Y_W-1:0] V_Y = Y_W'(V_ACTIVE);

    logic [1:0]     rst_sync_r;
    logic           rst_n_s;
    cap_state_t     state_r, state_nx_s;
    logic           vs_rise_s, vs_fall_s, href_rise_s, href_fall_s;
    logic           frame_begin_s, frame_end_s, capture_s, pix_complete_s;
    logic           pix_inb_s, line_close_s, line_bad_s;
    logic           phase_r, single_done_r;
    rgb565_t        pix_data_r;
    logic           pix_valid_r, frame_start_r, frame_done_r;
    logic           line_err_r, overflow_r;
    logic [X_W-1:0] pix_x_r;
    logic [X_W:0]   pix_cnt_r;
    logic [Y_W-1:0] pix_y_r;
    logic [7:0]     frame_cnt_r;

    // Reset asserts immediately but releases on a clock edge
    always_ff @(posedge PCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_n_s = rst_sync_r[1];

    sig_edge u_vs_edge (
        .clk   (PCLK),
        .rst_n (rst_n_s),
        .d     (VSYNC),
        .rise  (vs_rise_s),
        .fall  (vs_fall_s)
    );

    sig_edge u_href_edge (
        .clk   (PCLK),
        .rst_n (rst_n_s),
        .d     (HREF),
        .rise  (href_rise_s),
        .fall  (href_fall_s)
    );

    // Next-state logic and per-cycle capture/line-close decisions
    always_comb begin
        state_nx_s     = state_r;
        frame_begin_s  = 1'b0;
        frame_end_s    = 1'b0;
        capture_s      = 1'b0;
        line_close_s   = 1'b0;
        line_bad_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // a finished single-frame capture needs CAPTURE_EN dropped before re-arming
                if (CAPTURE_EN && !single_done_r) begin
                    state_nx_s = ST_WAIT_VS;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WAIT_VS: begin
                if (!CAPTURE_EN) begin
                    state_nx_s = ST_IDLE;
                end else if (vs_fall_s) begin
                    state_nx_s    = ST_ACTIVE;
                    frame_begin_s = 1'b1;
                end else begin
                    state_nx_s = ST_WAIT_VS;
                end
            end
            ST_ACTIVE: begin
                capture_s    = HREF && !vs_rise_s;
                line_close_s = href_fall_s || (vs_rise_s && HREF);
                line_bad_s   = (vs_rise_s && HREF) || (pix_cnt_r != H_C) || phase_r;
                if (vs_rise_s) begin
                    frame_end_s = 1'b1;
                    if (CAPTURE_EN && CONTINUOUS) begin
                        state_nx_s = ST_WAIT_VS;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end else begin
                    state_nx_s = ST_ACTIVE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
        pix_complete_s = capture_s && phase_r;
        pix_inb_s      = (pix_x_r < H_X) && (pix_y_r < V_Y);
    end

    // FSM state register and single-shot hold flag
    always_ff @(posedge PCLK or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_r       <= ST_IDLE;
            single_done_r <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            if (!CAPTURE_EN) begin
                single_done_r <= 1'b0;
            end else if (frame_end_s && !CONTINUOUS) begin
                single_done_r <= 1'b1;
            end
        end
    end

    // Pixel assembly, coordinates, flags and frame counter
    always_ff @(posedge PCLK or negedge rst_n_s) begin
        if (!rst_n_s) begin
            phase_r       <= 1'b0;
            pix_data_r    <= 16'h0000;
            pix_valid_r   <= 1'b0;
            pix_x_r       <= {X_W{1'b0}};
            pix_y_r       <= {Y_W{1'b0}};
            pix_cnt_r     <= {(X_W + 1){1'b0}};
            frame_start_r <= 1'b0;
            frame_done_r  <= 1'b0;
            line_err_r    <= 1'b0;
            overflow_r    <= 1'b0;
            frame_cnt_r   <= 8'd0;
        end else begin
            frame_start_r <= frame_begin_s;
            frame_done_r  <= frame_end_s;
            pix_valid_r   <= pix_complete_s && pix_inb_s;
            phase_r       <= capture_s ? ~phase_r : 1'b0;
            if (frame_end_s) begin
                frame_cnt_r <= frame_cnt_r + 8'd1;
            end
            if (capture_s && !phase_r) begin
                pix_data_r[15:8] <= DATA_IN;
            end else if (pix_complete_s) begin
                pix_data_r[7:0] <= DATA_IN;
            end
            if (frame_begin_s) begin
                pix_x_r    <= {X_W{1'b0}};
                pix_y_r    <= {Y_W{1'b0}};
                pix_cnt_r  <= {(X_W + 1){1'b0}};
                line_err_r <= 1'b0;
                overflow_r <= 1'b0;
            end else begin
                if (line_close_s) begin
                    pix_x_r   <= {X_W{1'b0}};
                    pix_y_r   <= sat_inc_y(pix_y_r, V_Y);
                    pix_cnt_r <= {(X_W + 1){1'b0}};
                    if (line_bad_s) begin
                        line_err_r <= 1'b1;
                    end
                end else begin
                    if (pix_valid_r) begin
                        pix_x_r <= pix_x_r + X_W'(1);
                    end
                    if (pix_complete_s && (pix_cnt_r != {(X_W + 1){1'b1}})) begin
                        pix_cnt_r <= pix_cnt_r + (X_W + 1)'(1);
                    end
                end
                if (pix_valid_r && !PIX_READY) begin
                    overflow_r <= 1'b1;
                end
            end
        end
    end

    assign PIX_DATA    = pix_data_r;
    assign PIX_VALID   = pix_valid_r;
    assign PIX_X       = pix_x_r;
    assign PIX_Y       = pix_y_r;
    assign FRAME_START = frame_start_r;
    assign FRAME_DONE  = frame_done_r;
    assign LINE_ERR    = line_err_r;
    assign OVERFLOW    = overflow_r;
    assign FRAME_CNT   = frame_cnt_r;

endmodule

// File: tb/tb_frame_capture.sv
// Directed bench for frame_capture with a 4x2 geometry; a negedge monitor
// logs pixels and pulse counts, the initial block checks them step by step.
module tb_frame_capture;

    logic        PCLK = 1'b0;
    logic        RESET_N, VSYNC, HREF, CAPTURE_EN, CONTINUOUS, PIX_READY;
    logic [7:0]  DATA_IN;
    logic [15:0] PIX_DATA;
    logic        PIX_VALID, FRAME_START, FRAME_DONE, LINE_ERR, OVERFLOW;
    logic [9:0]  PIX_X;
    logic [8:0]  PIX_Y;
    logic [7:0]  FRAME_CNT;

    int          vectors = 0;
    int          miscompares = 0;
    int          starts = 0;
    int          dones = 0;
    logic [34:0] pix_q[$];
    logic [7:0]  nb;
    int          base, s0, d0;

    frame_capture #(.H_ACTIVE(4), .V_ACTIVE(2)) dut (
        .PCLK(PCLK), .RESET_N(RESET_N), .VSYNC(VSYNC), .HREF(HREF),
        .DATA_IN(DATA_IN), .CAPTURE_EN(CAPTURE_EN), .CONTINUOUS(CONTINUOUS),
        .PIX_READY(PIX_READY), .PIX_DATA(PIX_DATA), .PIX_VALID(PIX_VALID),
        .PIX_X(PIX_X), .PIX_Y(PIX_Y), .FRAME_START(FRAME_START),
        .FRAME_DONE(FRAME_DONE), .LINE_ERR(LINE_ERR), .OVERFLOW(OVERFLOW),
        .FRAME_CNT(FRAME_CNT)
    );

    always #5 PCLK = ~PCLK;

    always @(negedge PCLK) begin
        if (PIX_VALID) pix_q.push_back({PIX_DATA, PIX_X, PIX_Y});
        if (FRAME_START) starts++;
        if (FRAME_DONE) dones++;
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // bytes run 0x12, 0x34, 0x56 ... (step 0x22) from the start of a frame
    function automatic logic [15:0] exp_pix(input int bi);
        logic [7:0] a, b;
        a = 8'h12 + 8'(34 * bi);
        b = 8'h12 + 8'(34 * (bi + 1));
        return {a, b};
    endfunction

    task automatic chk_pix(input string tag, input int idx, input logic [15:0] d,
                           input int x, input int y);
        if (idx < pix_q.size()) begin
            chk({tag, "_data"}, 32'(pix_q[idx][34:19]), 32'(d));
            chk({tag, "_x"}, 32'(pix_q[idx][18:9]), x);
            chk({tag, "_y"}, 32'(pix_q[idx][8:0]), y);
        end else begin
            chk({tag, "_present"}, pix_q.size(), idx + 1);
        end
    endtask

    task automatic send_line(input int nbytes, input int drop_at);
        for (int j = 0; j < nbytes; j++) begin
            HREF = 1'b1;
            DATA_IN = nb;
            nb = nb + 8'h22;
            PIX_READY = (j == drop_at) ? 1'b0 : 1'b1;
            tick();
        end
        HREF = 1'b0;
        DATA_IN = 8'h00;
        PIX_READY = 1'b1;
        repeat (3) tick();
    endtask

    task automatic frame_begin();
        VSYNC = 1'b0;
        repeat (2) tick();
    endtask

    task automatic frame_end();
        VSYNC = 1'b1;
        repeat (2) tick();
    endtask

    initial begin
        RESET_N = 1'b0; VSYNC = 1'b1; HREF = 1'b0; DATA_IN = 8'h00;
        CAPTURE_EN = 1'b0; CONTINUOUS = 1'b0; PIX_READY = 1'b1; nb = 8'h12;
        repeat (3) tick();
        chk("rst_valid", PIX_VALID, 0);
        chk("rst_data", PIX_DATA, 0);
        chk("rst_cnt", FRAME_CNT, 0);
        chk("rst_flags", {LINE_ERR, OVERFLOW, FRAME_START, FRAME_DONE}, 0);
        RESET_N = 1'b1;
        repeat (3) tick();

        // 4x2 frame plus an extra line beyond V_ACTIVE
        CAPTURE_EN = 1'b1; CONTINUOUS = 1'b1;
        tick();
        base = pix_q.size(); s0 = starts; d0 = dones; nb = 8'h12;
        frame_begin();
        send_line(8, -1); send_line(8, -1); send_line(8, -1);
        chk("s1_y_sat", PIX_Y, 2);
        frame_end();
        chk("s1_npix", pix_q.size() - base, 8);
        chk_pix("s1_p0", base, 16'h1234, 0, 0);
        for (int k = 1; k < 8; k++) chk_pix($sformatf("s1_p%0d", k), base + k, exp_pix(2 * k), k % 4, k / 4);
        chk("s1_starts", starts - s0, 1);
        chk("s1_dones", dones - d0, 1);
        chk("s1_fcnt", FRAME_CNT, 1);
        chk("s1_flags", {LINE_ERR, OVERFLOW}, 0);

        // short line of 3 pixels
        base = pix_q.size(); nb = 8'h12;
        frame_begin();
        chk("s2_lerr_pre", LINE_ERR, 0);
        send_line(6, -1);
        chk("s2_lerr", LINE_ERR, 1);
        chk("s2_npix_l1", pix_q.size() - base, 3);
        send_line(8, -1);
        chk_pix("s2_l2p0", base + 3, exp_pix(6), 0, 1);
        frame_end();
        chk("s2_lerr_hold", LINE_ERR, 1);
        chk("s2_fcnt", FRAME_CNT, 2);

        // odd byte count; next FRAME_START clears the previous LINE_ERR
        base = pix_q.size(); nb = 8'h12;
        frame_begin();
        chk("s3_lerr_clr", LINE_ERR, 0);
        send_line(7, -1);
        chk("s3_npix", pix_q.size() - base, 3);
        chk_pix("s3_p2", base + 2, 16'h9ABC, 2, 0);
        chk("s3_lerr", LINE_ERR, 1);
        frame_end();

        // PIX_READY low during the second pixel
        base = pix_q.size(); nb = 8'h12;
        frame_begin();
        chk("s4_lerr_clr", LINE_ERR, 0);
        chk("s4_ovf_pre", OVERFLOW, 0);
        send_line(8, 4);
        chk("s4_ovf", OVERFLOW, 1);
        send_line(8, -1);
        frame_end();
        chk("s4_npix", pix_q.size() - base, 8);
        chk_pix("s4_p2", base + 2, 16'h9ABC, 2, 0);
        chk("s4_ovf_hold", OVERFLOW, 1);
        chk("s4_fcnt", FRAME_CNT, 4);

        // single-frame mode over three camera frames
        CONTINUOUS = 1'b0;
        base = pix_q.size(); s0 = starts; d0 = dones;
        for (int f = 0; f < 3; f++) begin
            nb = 8'h12;
            frame_begin(); send_line(8, -1); send_line(8, -1); frame_end();
        end
        chk("s5_starts", starts - s0, 1);
        chk("s5_dones", dones - d0, 1);
        chk("s5_npix", pix_q.size() - base, 8);
        chk("s5_fcnt", FRAME_CNT, 5);

        // reset mid-line, then re-arm
        CONTINUOUS = 1'b1; CAPTURE_EN = 1'b0; tick(); CAPTURE_EN = 1'b1; tick();
        nb = 8'h12;
        frame_begin();
        for (int j = 0; j < 3; j++) begin
            HREF = 1'b1; DATA_IN = nb; nb = nb + 8'h22; tick();
        end
        chk("s6_x_pre", PIX_X, 1);
        RESET_N = 1'b0;
        #1;
        chk("s6_rst_data", PIX_DATA, 0);
        chk("s6_rst_xy", {PIX_X, PIX_Y}, 0);
        chk("s6_rst_valid", PIX_VALID, 0);
        chk("s6_rst_cnt", FRAME_CNT, 0);
        chk("s6_rst_flags", {LINE_ERR, OVERFLOW, FRAME_START, FRAME_DONE}, 0);
        repeat (2) tick();
        RESET_N = 1'b1;
        base = pix_q.size(); s0 = starts;
        for (int j = 0; j < 5; j++) begin
            HREF = 1'b1; DATA_IN = nb; nb = nb + 8'h22; tick();
        end
        HREF = 1'b0; repeat (3) tick();
        send_line(8, -1);
        frame_end();
        chk("s6_nopix", pix_q.size() - base, 0);
        chk("s6_nostart", starts - s0, 0);
        nb = 8'h12;
        frame_begin(); send_line(8, -1); send_line(8, -1); frame_end();
        chk("s6_npix", pix_q.size() - base, 8);
        chk_pix("s6_p0", base, 16'h1234, 0, 0);
        chk("s6_fcnt", FRAME_CNT, 1);

        // run the counter round to wrap
        d0 = dones;
        for (int f = 0; f < 254; f++) begin
            frame_begin(); frame_end();
        end
        chk("s7_fcnt_255", FRAME_CNT, 255);
        frame_begin(); frame_end();
        chk("s7_fcnt_wrap", FRAME_CNT, 0);
        chk("s7_dones", dones - d0, 255);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
